// File: rtl/apb_master.sv
// APB requester: accepts one valid/ready command, runs a single SETUP+ACCESS transfer,
// and returns read data with error/timeout status on a valid/ready response port.
module apb_master #(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int TO_CYC = 16,
    localparam int SW    = DW / 8
) (
    input  logic          pclk,
    input  logic          presetn,
    input  logic          i_cmd_valid,
    output logic          o_cmd_ready,
    input  logic          i_cmd_write,
    input  logic [AW-1:0] i_cmd_addr,
    input  logic [DW-1:0] i_cmd_wdata,
    input  logic [SW-1:0] i_cmd_strb,
    output logic          o_rsp_valid,
    input  logic          i_rsp_ready,
    output logic [DW-1:0] o_rsp_rdata,
    output logic          o_rsp_err,
    output logic          o_rsp_timeout,
    output logic [AW-1:0] o_paddr,
    output logic          o_pwrite,
    output logic          o_psel,
    output logic          o_penable,
    output logic [DW-1:0] o_pwdata,
    output logic [SW-1:0] o_pstrb,
    input  logic [DW-1:0] i_prdata,
    input  logic          i_pready,
    input  logic          i_pslverr
);

    localparam int CW = $clog2(TO_CYC + 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] paddr_q, paddr_d;
    logic          pwrite_q, pwrite_d;
    logic          psel_q, psel_d;
    logic          penable_q, penable_d;
    logic [DW-1:0] pwdata_q, pwdata_d;
    logic [SW-1:0] pstrb_q, pstrb_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;
    logic          rsp_timeout_q, rsp_timeout_d;

    logic          last_wait;
    assign last_wait = (cnt_q == CW'(TO_CYC - 1));

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            paddr_q       <= paddr_d;
            pwrite_q      <= pwrite_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_cmd_valid) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (i_pready || last_wait) state_d = RESP;
            RESP:    if (i_rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d         = cnt_q;
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        case (state_q)
            IDLE: begin
                if (i_cmd_valid) begin
                    paddr_d   = i_cmd_addr;
                    pwrite_d  = i_cmd_write;
                    pwdata_d  = i_cmd_wdata;
                    pstrb_d   = i_cmd_write ? i_cmd_strb : '0;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
            end
            ACCESS: begin
                // pwrite/pstrb drop with psel so they read 0 whenever the bus is idle
                if (i_pready) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    pwrite_d      = 1'b0;
                    pstrb_d       = '0;
                    rsp_rdata_d   = (pwrite_q || i_pslverr) ? '0 : i_prdata;
                    rsp_err_d     = i_pslverr;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                end else if (last_wait) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    pwrite_d      = 1'b0;
                    pstrb_d       = '0;
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = 1'b1;
                end else if (cnt_q != {CW{1'b1}}) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                if (i_rsp_ready) rsp_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign o_cmd_ready   = (state_q == IDLE);
    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_rdata   = rsp_rdata_q;
    assign o_rsp_err     = rsp_err_q;
    assign o_rsp_timeout = rsp_timeout_q;
    assign o_paddr       = paddr_q;
    assign o_pwrite      = pwrite_q;
    assign o_psel        = psel_q;
    assign o_penable     = penable_q;
    assign o_pwdata      = pwdata_q;
    assign o_pstrb       = pstrb_q;

endmodule
